mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative MIPS multiply/divide unit owning the HI/LO architectural registers.
//  Sits downstream of the register file: consumes RD1/RD2 (rs/rt) and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//  Exposes HI/LO to the writeback mux for MFHI/MFLO. Controller stalls MFHI/MFLO and new mult/div while busy.
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are each WIDTH bits
// PORTS
//  clk      in   1      single clock, rising edge
//  reset    in   1      asynchronous, active-high; clears all state
//  start    in   1      request strobe, sampled on rising clk
//  op       in   3      mdu_op_t: MULT=0 MULTU=1 DIV=2 DIVU=3 MTHI=4 MTLO=5 (6,7 = no-op)
//  rs_data  in   WIDTH  operand A (RD1): multiplicand / dividend / MTHI-MTLO source
//  rt_data  in   WIDTH  operand B (RD2): multiplier / divisor
//  busy     out  1      iterative operation in progress
//  done     out  1      one-cycle pulse: result just committed to HI/LO
//  hi       out  WIDTH  HI register (remainder, or upper product)
//  lo       out  WIDTH  LO register (quotient, or lower product)
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-op): state=IDLE, busy=0, done=0, hi=0, lo=0; partial result discarded.
//  - FSM states: IDLE, RUN, FIN.
//    - IDLE: start & op in {0..3}: latch |A|,|B| (signed ops) or A,B (unsigned), record result signs, cnt=0 -> RUN.
//    - IDLE: start & op=MTHI: hi<=rs_data; op=MTLO: lo<=rs_data. Stay IDLE; done stays 0.
//    - RUN: one shift-add (mult) or restoring-subtract (div) step per cycle; cnt++; cnt==WIDTH-1 -> FIN.
//    - FIN: apply sign fix, hi/lo<=result, done=1 for this cycle, busy=0 -> IDLE.
//  - busy=1 exactly in RUN. Start edge at cycle 0 gives RUN in cycles 1..WIDTH and FIN (done) in cycle WIDTH+1.
//    Latency is WIDTH+1 cycles from the start edge to done.
//  - start while busy (RUN/FIN) is ignored; no queuing. Accepted again from the cycle after FIN.
//  - hi/lo are unchanged from the start edge until FIN, so MFHI/MFLO read stale values during busy.
//  - Mult: 2*WIDTH-bit product; hi=upper WIDTH bits, lo=lower WIDTH bits.
//    MULT: result negated (two's complement, 2W bits) iff sign(A)^sign(B).
//  - Div: lo=quotient, hi=remainder. DIV: quotient sign=sign(A)^sign(B); remainder sign=sign(A) (truncating).
//  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps naturally; no trap).
//  - Divide by zero (B==0, DIV or DIVU): IDLE->FIN directly, skipping RUN.
//    Result hi=rs_data, lo={WIDTH{1'b1}}; done in the cycle after the start edge.
//  - Ops 6,7 with start: ignored, no state change.
// CONFIGURATION
//  - MDU_SINGLE_CYCLE_MULT_EN defined: MULT/MULTU skip RUN (IDLE->FIN) using a combinational `*`.
//    done arrives 1 cycle after start; DIV/DIVU unchanged.
//  - Undefined: all multiplies are iterative (WIDTH+1 cycles), no hardware multiplier inferred.
// STRUCTURE
//  - mips_pkg: typedef enum logic [2:0] mdu_op_t (values above); typedef enum mdu_state_t {IDLE,RUN,FIN}.
//  - One sub-module: mdu_div_step: combinational restoring step (rem,quot,divisor) -> (rem',quot').
//    Instantiated once; the multiply step stays inline.
// TESTING
//  - MULTU 0xFFFFFFFF*0xFFFFFFFF -> done exactly 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy=1 for 32 cycles.
//  - MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
//  - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
//  - DIVU 5/0 -> done 1 cycle after start; hi=5, lo=0xFFFFFFFF.
//  - MTHI 0x12345678 then MTLO 0xCAFEF00D -> hi/lo update next edge, done=0; start mid-RUN ignored, result unaffected.
//  - Reset asserted at RUN cycle 10 -> immediately busy=0, hi=lo=0. After release, MULTU 3*4 -> lo=12, hi=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the MIPS multiply/divide unit: opcode encoding and FSM states.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mdu_state_t;

  // Ops 0..3 are the iterative arithmetic ops; bit 1 selects divide, bit 0 unsigned.
  function automatic logic is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quot_n
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;
  logic           ge;

  // Remainder is always below the divisor, so the trial value fits in WIDTH+1
  // bits and the top bit of the difference is a clean borrow flag.
  always_comb begin
    trial  = {rem, quot[WIDTH-1]};
    diff   = trial - {1'b0, divisor};
    ge     = ~diff[WIDTH];
    rem_n  = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quot_n = {quot[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO.
// Optional feature macro: MDU_SINGLE_CYCLE_MULT_EN makes MULT/MULTU finish in
// one cycle with a combinational multiplier; divides stay iterative.
// HI/LO are written on the edge that enters FIN, so they already hold the new
// result while done is high.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t state, state_n;

  logic [WIDTH:0]   acc;      // mult: running upper product; div: partial remainder
  logic [WIDTH-1:0] mq;       // mult: multiplier / low product; div: dividend / quotient
  logic [WIDTH-1:0] bop;      // multiplicand or divisor magnitude
  logic [CW-1:0]    cnt;
  logic             div_mode;
  logic             neg_a;    // signed op with negative A: remainder sign
  logic             neg_x;    // signed op with sign(A)^sign(B): product/quotient sign

  logic             sgn;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             arith, div_zero, fast;
  logic             last;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_mq_n;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   div_rem_n, div_quot_n;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [2*WIDTH-1:0] fast_prod;

  // Operand magnitudes and request decode at the start edge.
  always_comb begin
    sgn      = ~op[0];
    a_abs    = (sgn && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    b_abs    = (sgn && rt_data[WIDTH-1]) ? -rt_data : rt_data;
    arith    = start && is_arith(op);
    div_zero = arith && op[1] && (rt_data == '0);
    last     = (cnt == CW'(WIDTH-1));
  end

`ifdef MDU_SINGLE_CYCLE_MULT_EN
  // Full-width signed or unsigned product for the single-cycle multiply path.
  always_comb begin
    fast = arith && !op[1];
    if (sgn)
      fast_prod = $signed({{WIDTH{rs_data[WIDTH-1]}}, rs_data}) *
                  $signed({{WIDTH{rt_data[WIDTH-1]}}, rt_data});
    else
      fast_prod = {{WIDTH{1'b0}}, rs_data} * {{WIDTH{1'b0}}, rt_data};
  end
`else
  // Every multiply goes through the shift-add loop.
  always_comb begin
    fast      = 1'b0;
    fast_prod = '0;
  end
`endif

  // Shift-add multiply step: add multiplicand on LSB, shift the pair right.
  always_comb begin
    mul_sum  = mq[0] ? (acc + {1'b0, bop}) : acc;
    mul_mq_n = {mul_sum[0], mq[WIDTH-1:1]};
    prod     = {mul_sum[WIDTH:1], mul_mq_n};
  end

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem     (acc[WIDTH-1:0]),
    .quot    (mq),
    .divisor (bop),
    .rem_n   (div_rem_n),
    .quot_n  (div_quot_n)
  );

  // Sign fix of the final step result before it is committed to HI/LO.
  always_comb begin
    if (div_mode) begin
      res_lo = neg_x ? -div_quot_n : div_quot_n;
      res_hi = neg_a ? -div_rem_n  : div_rem_n;
    end else begin
      {res_hi, res_lo} = neg_x ? -prod : prod;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state: divide-by-zero and single-cycle multiply bypass RUN.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (arith) state_n = (div_zero || fast) ? FIN : RUN;
      RUN:     if (last)  state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Status outputs.
  always_comb begin
    busy = (state == RUN);
    done = (state == FIN);
  end

  // Datapath: operand capture, iteration, and HI/LO writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      mq       <= '0;
      bop      <= '0;
      cnt      <= '0;
      div_mode <= 1'b0;
      neg_a    <= 1'b0;
      neg_x    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && op == OP_MTHI) hi <= rs_data;
          if (start && op == OP_MTLO) lo <= rs_data;
          if (div_zero) begin
            hi <= rs_data;
            lo <= '1;
          end else if (fast) begin
            {hi, lo} <= fast_prod;
          end else if (arith) begin
            acc      <= '0;
            mq       <= a_abs;
            bop      <= b_abs;
            cnt      <= '0;
            div_mode <= op[1];
            neg_a    <= sgn && rs_data[WIDTH-1];
            neg_x    <= sgn && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (div_mode) begin
            acc <= {1'b0, div_rem_n};
            mq  <= div_quot_n;
          end else begin
            acc <= {1'b0, mul_sum[WIDTH:1]};
            mq  <= mul_mq_n;
          end
          if (last) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a vector table of ops with hand-computed
// HI/LO and latency, plus sequences for MTHI/MTLO, start-while-busy and reset.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MDU_SINGLE_CYCLE_MULT_EN
  localparam int MLAT = 1;
`else
  localparam int MLAT = 33;
`endif

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Launch one op at the next edge; count cycles (sampled at negedge) until done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (done) break;
    end
  endtask

  initial begin
    int lat, bc;
    vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MLAT};
    vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, MLAT};
    vecs[2]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MLAT};
    vecs[3]  = '{3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MLAT};
    vecs[4]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[5]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[6]  = '{3'd3, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1};
    vecs[7]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[8]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
    vecs[9]  = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1};
    vecs[10] = '{3'd3, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 33};

    reset = 1'b1; start = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      if (vecs[i].lat == 33)
        chk($sformatf("v%0d_busy_cycles", i), bc, 32);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // MTHI / MTLO write on the next edge without a done pulse.
    @(negedge clk);
    op = 3'd4; rs_data = 32'h12345678; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    op = 3'd5; rs_data = 32'hCAFEF00D; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("mtlo_lo", lo, 32'hCAFEF00D);
    chk("mtlo_hi_kept", hi, 32'h12345678);
    chk("mtlo_done", {31'd0, done}, 32'd0);

    // Op 7 is a no-op.
    @(negedge clk);
    op = 3'd7; rs_data = 32'h0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_hi", hi, 32'h12345678);

    // Start mid-RUN is ignored; HI/LO stale during busy.
    @(negedge clk);
    op = 3'd3; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    op = 3'd5; rs_data = 32'hDEADBEEF; rt_data = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("stale_lo", lo, 32'hCAFEF00D);
    lat = 6;
    while (lat < 100 && !done) begin
      @(negedge clk);
      lat++;
    end
    chk("midrun_lat", lat, 33);
    chk("midrun_lo", lo, 32'd14);
    chk("midrun_hi", hi, 32'd2);

    // Reset during RUN clears everything immediately; then a fresh MULTU.
    @(negedge clk);
    op = 3'd1; rs_data = 32'hFFFF; rt_data = 32'hFFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_hi", hi, 32'd0);
    chk("midreset_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd1, 32'd3, 32'd4, lat, bc);
    chk("post_reset_lat", lat, MLAT);
    chk("post_reset_lo", lo, 32'd12);
    chk("post_reset_hi", hi, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
